// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit code type, special code values and
// the active-low {g,f,e,d,c,b,a} patterns used by the scanner and encoder.
package seg7_pkg;

  typedef logic [3:0] digit_code_t;

  localparam digit_code_t SEG_MINUS = 4'd10;
  localparam digit_code_t SEG_BLANK = 4'd11;
  localparam digit_code_t SEG_E     = 4'd12;
  localparam digit_code_t SEG_R     = 4'd13;

  localparam logic [6:0] PAT_0     = 7'b1000000;
  localparam logic [6:0] PAT_1     = 7'b1111001;
  localparam logic [6:0] PAT_2     = 7'b0100100;
  localparam logic [6:0] PAT_3     = 7'b0110000;
  localparam logic [6:0] PAT_4     = 7'b0011001;
  localparam logic [6:0] PAT_5     = 7'b0010010;
  localparam logic [6:0] PAT_6     = 7'b0000010;
  localparam logic [6:0] PAT_7     = 7'b1111000;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0010000;
  localparam logic [6:0] PAT_MINUS = 7'b0111111;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_E     = 7'b0000110;
  localparam logic [6:0] PAT_R     = 7'b0101111;

  // Codes that count as "nothing significant" when looking for leading zeros.
  function automatic logic is_zero_or_dark(digit_code_t code);
    return (code == 4'd0) || (code == SEG_BLANK) || (code == 4'd15);
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Digit data in / anode+cathode drive out bundle for display_scan.
// master = the side supplying digits, slave = the scanner.
interface display_scan_if;
  logic [15:0] digits_in;
  logic        dp_en;
  logic        blank;
  logic [3:0]  anode;
  logic [7:0]  seg;
  logic [1:0]  digit_sel;
  logic        scan_tick;

  modport master (
    output digits_in, dp_en, blank,
    input  anode, seg, digit_sel, scan_tick
  );

  modport slave (
    input  digits_in, dp_en, blank,
    output anode, seg, digit_sel, scan_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low 7-segment pattern decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_code_t code,
  output logic [6:0]  pattern
);

  always_comb begin
    pattern = PAT_BLANK;
    case (code)
      4'd0:      pattern = PAT_0;
      4'd1:      pattern = PAT_1;
      4'd2:      pattern = PAT_2;
      4'd3:      pattern = PAT_3;
      4'd4:      pattern = PAT_4;
      4'd5:      pattern = PAT_5;
      4'd6:      pattern = PAT_6;
      4'd7:      pattern = PAT_7;
      4'd8:      pattern = PAT_8;
      4'd9:      pattern = PAT_9;
      SEG_MINUS: pattern = PAT_MINUS;
      SEG_E:     pattern = PAT_E;
      SEG_R,
      4'd14:     pattern = PAT_R;
      default:   pattern = PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with registered anode/seg/digit_sel.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module display_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 3
) (
  input  logic         clk_in,
  input  logic         rst_n,
  display_scan_if.slave bus
);

  localparam int         PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);
  localparam logic [1:0] DP_IDX = 2'(DP_POS);

  logic [PW-1:0] prescaler_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    anode_reg;
  logic [7:0]    seg_reg;
  logic [1:0]    digit_sel_reg;
  logic          scan_tick_reg;

  digit_code_t raw_code [4];
  digit_code_t eff_code [4];
  digit_code_t cur_code;
  logic [6:0]  cur_pattern;
  logic        terminal;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_raw
      assign raw_code[gi] = bus.digits_in[4*gi +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // clear_above[k]: every digit above k is zero or blank-coded.
    logic [3:1] clear_above;
    assign clear_above[3] = 1'b1;
    for (gi = 1; gi < 3; gi++) begin : g_clear
      assign clear_above[gi] = clear_above[gi+1] & is_zero_or_dark(raw_code[gi+1]);
    end
    assign eff_code[0] = raw_code[0];
    for (gi = 1; gi < 4; gi++) begin : g_lzb
      assign eff_code[gi] = ((raw_code[gi] == 4'd0) && clear_above[gi]) ? SEG_BLANK
                                                                         : raw_code[gi];
    end
`else
    for (gi = 0; gi < 4; gi++) begin : g_lit
      assign eff_code[gi] = raw_code[gi];
    end
`endif
  endgenerate

  assign cur_code = eff_code[idx_reg];
  assign terminal = (prescaler_reg == TERM);

  seg7_decode u_decode (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  // Outputs are built from the pre-advance idx, so anode/seg/digit_sel stay paired.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      idx_reg       <= 2'd0;
      anode_reg     <= 4'b1111;
      seg_reg       <= 8'hFF;
      digit_sel_reg <= 2'd0;
      scan_tick_reg <= 1'b0;
    end else begin
      if (terminal) begin
        prescaler_reg <= '0;
        idx_reg       <= idx_reg + 2'd1;
        scan_tick_reg <= 1'b1;
      end else begin
        prescaler_reg <= prescaler_reg + PW'(1);
        scan_tick_reg <= 1'b0;
      end

      digit_sel_reg <= idx_reg;
      if (bus.blank) begin
        anode_reg <= 4'b1111;
        seg_reg   <= 8'hFF;
      end else begin
        anode_reg <= ~(4'b0001 << idx_reg);
        seg_reg   <= {~(bus.dp_en && (idx_reg == DP_IDX)), cur_pattern};
      end
    end
  end

  assign bus.anode     = anode_reg;
  assign bus.seg       = seg_reg;
  assign bus.digit_sel = digit_sel_reg;
  assign bus.scan_tick = scan_tick_reg;

endmodule
